div_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU on the pipelined core. Accepts one

---
 rtl/div_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer using a restoring shift-subtract datapath.
// Latency: 32/STEPS_PER_CYCLE cycles from accept to resp_valid; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: one op in flight; req_ready only in IDLE without flush; the result is held until resp_ready.
module div_seq_ctrl #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        busy
);

  localparam logic [5:0] STEP = 6'(STEPS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        is_rem_q, is_rem_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  rd_q, rd_d;

  // One restoring step on {partial remainder, dividend/quotient}.
  function automatic logic [63:0] divu_1iter(input logic [63:0] rq, input logic [31:0] d);
    logic [32:0] r;
    logic [31:0] q;
    r = {rq[63:32], rq[31]};
    q = {rq[30:0], 1'b0};
    if (r >= {1'b0, d}) begin
      r    = r - {1'b0, d};
      q[0] = 1'b1;
    end
    return {r[31:0], q};
  endfunction

  logic        is_signed;
  logic [31:0] a_abs, b_abs;
  logic        div_zero, sgn_ovf, accept;
  logic [63:0] iter_rq;
  logic [31:0] iter_dvs;
  logic [31:0] q_fix, r_fix;
  logic [5:0]  cnt_nxt;

  assign is_signed = ~req_op[0];
  assign a_abs     = (is_signed & req_a[31]) ? -req_a : req_a;
  assign b_abs     = (is_signed & req_b[31]) ? -req_b : req_b;
  assign div_zero  = (req_b == 32'd0);
  assign sgn_ovf   = is_signed & (req_a == 32'h8000_0000) & (req_b == 32'hFFFF_FFFF);
  assign accept    = req_valid & req_ready;
  assign cnt_nxt   = cnt_q + STEP;

  // The accept edge already performs the first group of steps.
  always_comb begin
    iter_rq  = (state_q == IDLE) ? {32'd0, a_abs} : {rem_q, quo_q};
    iter_dvs = (state_q == IDLE) ? b_abs : dvs_q;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      iter_rq = divu_1iter(iter_rq, iter_dvs);
    end
  end

  assign q_fix = q_neg_q ? -iter_rq[31:0]  : iter_rq[31:0];
  assign r_fix = r_neg_q ? -iter_rq[63:32] : iter_rq[63:32];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    data_d   = data_q;
    rd_d     = rd_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d     = req_rd;
          is_rem_d = req_op[1];
          q_neg_d  = is_signed & (req_a[31] ^ req_b[31]);
          r_neg_d  = is_signed & req_a[31];
          if (div_zero) begin
            data_d  = req_op[1] ? req_a : 32'hFFFF_FFFF;
            state_d = DONE;
          end else if (sgn_ovf) begin
            data_d  = req_op[1] ? 32'd0 : 32'h8000_0000;
            state_d = DONE;
          end else begin
            rem_d   = iter_rq[63:32];
            quo_d   = iter_rq[31:0];
            dvs_d   = b_abs;
            cnt_d   = STEP;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = iter_rq[63:32];
        quo_d = iter_rq[31:0];
        cnt_d = cnt_nxt;
        if (cnt_nxt == 6'd32) begin
          data_d  = is_rem_q ? r_fix : q_fix;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
          cnt_d   = 6'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      data_q   <= 32'd0;
      rd_q     <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
    end
  end

  assign req_ready  = (state_q == IDLE) & ~flush;
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_data  = data_q;
  assign resp_rd    = rd_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed vector table on a 1-step instance, corner sequences,
// and a random sweep on a 4-step instance against a behavioural reference.
module tb_div_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        resp_ready;

  logic        req_ready1, resp_valid1, busy1;
  logic [31:0] resp_data1;
  logic [4:0]  resp_rd1;
  logic        req_ready4, resp_valid4, busy4;
  logic [31:0] resp_data4;
  logic [4:0]  resp_rd4;

  logic        use4;
  logic        m_req_ready, m_resp_valid, m_busy;
  logic [31:0] m_resp_data;
  logic [4:0]  m_resp_rd;

  int n_cmp  = 0;
  int n_fail = 0;

  div_seq_ctrl #(.STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
    .resp_rd(resp_rd1), .busy(busy1)
  );

  div_seq_ctrl #(.STEPS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
    .resp_valid(resp_valid4), .resp_ready(resp_ready), .resp_data(resp_data4),
    .resp_rd(resp_rd4), .busy(busy4)
  );

  assign m_req_ready  = use4 ? req_ready4  : req_ready1;
  assign m_resp_valid = use4 ? resp_valid4 : resp_valid1;
  assign m_busy       = use4 ? busy4       : busy1;
  assign m_resp_data  = use4 ? resp_data4  : resp_data1;
  assign m_resp_rd    = use4 ? resp_rd4    : resp_rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request, wait (bounded) for req_ready, and return just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int g;
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    g = 0;
    while (!m_req_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (!m_req_ready) chk("issue_ready_timeout", 32'(m_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = ~a; req_b = ~b; req_op = ~op; req_rd = ~rd;
  endtask

  // Cycles from the accept edge up to the first cycle showing resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!m_resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  initial begin
    int lat;
    logic [1:0]  op;
    logic [31:0] a, b, e;
    logic [4:0]  rd;
    int          elat;
    bit          seen;

    vt[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         32};
    vt[1]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  32};
    vt[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  32};
    vt[3]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1};
    vt[4]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          1};
    vt[5]  = '{2'b01, 32'd1234,       32'd0,          5'd10, 32'hFFFF_FFFF,  1};
    vt[6]  = '{2'b11, 32'd1234,       32'd0,          5'd11, 32'd1234,       1};
    vt[7]  = '{2'b10, 32'hFFFF_FFFB,  32'd0,          5'd12, 32'hFFFF_FFFB,  1};
    vt[8]  = '{2'b00, 32'd20,         32'hFFFF_FFFD,  5'd13, 32'hFFFF_FFFA,  32};
    vt[9]  = '{2'b10, 32'd20,         32'hFFFF_FFFD,  5'd14, 32'd2,          32};
    vt[10] = '{2'b11, 32'hFFFF_FFFF,  32'd10,         5'd15, 32'd5,          32};
    vt[11] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd16, 32'hFFFF_FFFF,  32};
    vt[12] = '{2'b10, 32'hFFFF_FFF8,  32'd4,          5'd17, 32'd0,          32};
    vt[13] = '{2'b00, 32'h8000_0000,  32'd1,          5'd31, 32'h8000_0000,  32};

    use4 = 1'b0;
    req_valid = 1'b0; req_op = 2'b00; req_a = 32'd0; req_b = 32'd0; req_rd = 5'd0;
    flush = 1'b0; resp_ready = 1'b1;
    rst_n = 1'b0;

    #3;
    chk("rst_resp_valid", 32'(m_resp_valid), 32'd0);
    chk("rst_resp_data",  m_resp_data,       32'd0);
    chk("rst_resp_rd",    32'(m_resp_rd),    32'd0);
    chk("rst_busy",       32'(m_busy),       32'd0);
    #19 rst_n = 1'b1;
    #1;
    chk("rst_req_ready",  32'(m_req_ready),  32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].rd);
      wait_resp(lat);
      chk($sformatf("vec%0d_data", i), m_resp_data,  vt[i].exp);
      chk($sformatf("vec%0d_rd", i),   32'(m_resp_rd), 32'(vt[i].rd));
      chk($sformatf("vec%0d_lat", i),  32'(lat),     32'(vt[i].lat));
      @(posedge clk); #1;
    end

    // Held response under backpressure.
    resp_ready = 1'b0;
    issue(2'b01, 32'd100, 32'd7, 5'd3);
    wait_resp(lat);
    chk("bp_lat", 32'(lat), 32'd32);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid_held", 32'(m_resp_valid), 32'd1);
      chk("bp_data_held",  m_resp_data,       32'd14);
      chk("bp_rd_held",    32'(m_resp_rd),    32'd3);
      chk("bp_req_ready",  32'(m_req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(m_resp_valid), 32'd0);
    chk("bp_release_ready", 32'(m_req_ready),  32'd1);

    // Flush mid-CALC with a new request already waiting.
    issue(2'b01, 32'd100, 32'd7, 5'd4);
    seen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      seen |= m_resp_valid;
    end
    flush = 1'b1;
    req_op = 2'b01; req_a = 32'd9; req_b = 32'd3; req_rd = 5'd21; req_valid = 1'b1;
    #1;
    chk("flush_blocks_ready", 32'(m_req_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_no_resp",   32'(seen | m_resp_valid), 32'd0);
    chk("flush_idle",      32'(m_busy),      32'd0);
    chk("flush_ready_now", 32'(m_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("flush_next_accept", 32'(m_busy), 32'd1);
    wait_resp(lat);
    chk("flush_next_data", m_resp_data,    32'd3);
    chk("flush_next_rd",   32'(m_resp_rd), 32'd21);
    chk("flush_next_lat",  32'(lat),       32'd32);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of CALC.
    issue(2'b01, 32'd100, 32'd7, 5'd30);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy",       32'(m_busy),       32'd0);
    chk("arst_resp_valid", 32'(m_resp_valid), 32'd0);
    chk("arst_resp_data",  m_resp_data,       32'd0);
    chk("arst_resp_rd",    32'(m_resp_rd),    32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(2'b11, 32'd100, 32'd7, 5'd18);
    wait_resp(lat);
    chk("arst_after_data", m_resp_data,    32'd2);
    chk("arst_after_rd",   32'(m_resp_rd), 32'd18);
    chk("arst_after_lat",  32'(lat),       32'd32);
    @(posedge clk); #1;

    // Random sweep on the 4-step instance.
    use4 = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int n = 0; n < 1000; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 16));
        3: b = 32'd0 - 32'($urandom_range(1, 16));
        4: a = 32'($urandom_range(0, 100));
        default: ;
      endcase
      e    = ref_model(op, a, b);
      elat = ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 8;
      issue(op, a, b, rd);
      wait_resp(lat);
      chk($sformatf("sweep%0d_data op=%0d a=%h b=%h", n, op, a, b), m_resp_data, e);
      chk($sformatf("sweep%0d_rd", n),  32'(m_resp_rd), 32'(rd));
      chk($sformatf("sweep%0d_lat", n), 32'(lat),       32'(elat));
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
